// File: rtl/serv_wb_mem_responder_pkg.sv
// serv_wb_mem_responder_pkg
//   Shared constants for the Wishbone memory responder:
//   FSM state encodings, initiator port ids and a byte-lane merge helper.
package serv_wb_mem_responder_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam logic PORT_IBUS = 1'b0;
    localparam logic PORT_DBUS = 1'b1;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serv_wb_mem_responder_if.sv
// serv_wb_mem_responder_if
//   Bundles the core's two Wishbone initiator buses.
//   ibus: i_ibus_adr, i_ibus_cyc (initiator) / o_ibus_rdt, o_ibus_ack (responder)
//   dbus: i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc (initiator)
//         / o_dbus_rdt, o_dbus_ack (responder)
//   master modport = the core side, slave modport = the memory responder.
interface serv_wb_mem_responder_if;

    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;

    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;

    modport master (
        output i_ibus_adr, i_ibus_cyc,
        input  o_ibus_rdt, o_ibus_ack,
        output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        input  o_dbus_rdt, o_dbus_ack
    );

    modport slave (
        input  i_ibus_adr, i_ibus_cyc,
        output o_ibus_rdt, o_ibus_ack,
        input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        output o_dbus_rdt, o_dbus_ack
    );

endinterface

// File: rtl/serv_wb_mem_responder_ram.sv
// serv_wb_mem_ram
//   DEPTH/4 x 32 single-port RAM with per-byte write enables and a
//   registered, read-first output.
//   Ports: i_clk clock, i_addr word index, i_we byte write enables,
//          i_wdata write word, o_rdata registered read word.
module serv_wb_mem_ram
    import serv_wb_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 8192,
    parameter              MEMFILE = "",
    localparam int unsigned AW     = $clog2(DEPTH) - 2
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem_q [DEPTH/4];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = mem_q[i_addr];
    end

    // Read-first: the output register captures the word as it was before
    // a write on the same edge.
    always_ff @(posedge i_clk) begin
        if (|i_we) begin
            mem_q[i_addr] <= merge_lanes(mem_q[i_addr], i_wdata, i_we);
        end
        rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/serv_wb_mem_responder.sv
// serv_wb_mem_responder
//   Serves the core's instruction (ibus) and data (dbus) Wishbone buses
//   from one shared word RAM, one request at a time, dbus winning ties.
//   Each completed request gets a single-cycle ack, 2+WAIT_STATES cycles
//   after cyc is first seen.
//   Ports: i_clk clock, i_rst_n async active-low reset,
//          bus  slave side of serv_wb_mem_responder_if (ibus + dbus).
module serv_wb_mem_responder
    import serv_wb_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 8192,
    parameter int unsigned WAIT_STATES = 0,
    parameter              MEMFILE     = ""
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    serv_wb_mem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH) - 2;

    logic [1:0]    state_q,    state_d;
    logic          port_q,     port_d;
    logic [AW-1:0] adr_q,      adr_d;
    logic          we_q,       we_d;
    logic [3:0]    sel_q,      sel_d;
    logic [31:0]   dat_q,      dat_d;
    logic [3:0]    cnt_q,      cnt_d;
    logic          ibus_ack_q, ibus_ack_d;
    logic          dbus_ack_q, dbus_ack_d;
    logic [31:0]   ibus_rdt_q, ibus_rdt_d;
    logic [31:0]   dbus_rdt_q, dbus_rdt_d;

    logic          cyc_granted;
    logic          do_access;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;

    logic          unused_adr_bits;
    assign unused_adr_bits = ^{bus.i_ibus_adr[31:AW+2], bus.i_ibus_adr[1:0],
                               bus.i_dbus_adr[31:AW+2], bus.i_dbus_adr[1:0]};

    assign cyc_granted = (port_q == PORT_DBUS) ? bus.i_dbus_cyc : bus.i_ibus_cyc;
    assign do_access   = (state_q == ST_ACCESS) && cyc_granted && (cnt_q == 4'd0);

    // The RAM has a registered read, so it is addressed with the winning
    // request's address already in IDLE; the read word is then ready when
    // the access completes, even with zero wait states.
    always_comb begin
        if (state_q == ST_IDLE) begin
            ram_addr = bus.i_dbus_cyc ? bus.i_dbus_adr[AW+1:2] : bus.i_ibus_adr[AW+1:2];
        end else begin
            ram_addr = adr_q;
        end
    end

    assign ram_we = (do_access && (port_q == PORT_DBUS) && we_q) ? sel_q : '0;

    serv_wb_mem_ram #(
        .DEPTH   (DEPTH),
        .MEMFILE (MEMFILE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_addr  (ram_addr),
        .i_we    (ram_we),
        .i_wdata (dat_q),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        dat_d      = dat_q;
        cnt_d      = cnt_q;
        ibus_ack_d = 1'b0;
        dbus_ack_d = 1'b0;
        ibus_rdt_d = ibus_rdt_q;
        dbus_rdt_d = dbus_rdt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_dbus_cyc) begin
                    port_d  = PORT_DBUS;
                    adr_d   = bus.i_dbus_adr[AW+1:2];
                    we_d    = bus.i_dbus_we;
                    sel_d   = bus.i_dbus_sel;
                    dat_d   = bus.i_dbus_dat;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ST_ACCESS;
                end else if (bus.i_ibus_cyc) begin
                    port_d  = PORT_IBUS;
                    adr_d   = bus.i_ibus_adr[AW+1:2];
                    we_d    = 1'b0;
                    sel_d   = '0;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!cyc_granted) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (port_q == PORT_DBUS) begin
                        dbus_rdt_d = ram_rdata;
                        dbus_ack_d = 1'b1;
                    end else begin
                        ibus_rdt_d = ram_rdata;
                        ibus_ack_d = 1'b1;
                    end
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            port_q     <= PORT_IBUS;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
            cnt_q      <= '0;
            ibus_ack_q <= 1'b0;
            dbus_ack_q <= 1'b0;
            ibus_rdt_q <= '0;
            dbus_rdt_q <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            dat_q      <= dat_d;
            cnt_q      <= cnt_d;
            ibus_ack_q <= ibus_ack_d;
            dbus_ack_q <= dbus_ack_d;
            ibus_rdt_q <= ibus_rdt_d;
            dbus_rdt_q <= dbus_rdt_d;
        end
    end

    assign bus.o_ibus_ack = ibus_ack_q;
    assign bus.o_ibus_rdt = ibus_rdt_q;
    assign bus.o_dbus_ack = dbus_ack_q;
    assign bus.o_dbus_rdt = dbus_rdt_q;

endmodule

// File: tb/tb_serv_wb_mem_responder.sv
// tb_serv_wb_mem_responder
//   Directed bench for serv_wb_mem_responder. Two instances: u0 with
//   DEPTH=8192, WAIT_STATES=0 and u3 with DEPTH=64, WAIT_STATES=3.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_serv_wb_mem_responder;

    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst3_n = 1'b0;

    int nasserts = 0;
    int nfail    = 0;

    always #5 clk = ~clk;

    serv_wb_mem_responder_if b0 ();
    serv_wb_mem_responder_if b3 ();

    serv_wb_mem_responder #(
        .DEPTH       (8192),
        .WAIT_STATES (0),
        .MEMFILE     ("")
    ) u0 (
        .i_clk   (clk),
        .i_rst_n (rst0_n),
        .bus     (b0.slave)
    );

    serv_wb_mem_responder #(
        .DEPTH       (64),
        .WAIT_STATES (3),
        .MEMFILE     ("")
    ) u3 (
        .i_clk   (clk),
        .i_rst_n (rst3_n),
        .bus     (b3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasserts++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_d(input int d, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input logic cyc);
        if (d == 0) begin
            b0.i_dbus_adr = adr; b0.i_dbus_dat = dat; b0.i_dbus_sel = sel;
            b0.i_dbus_we  = we;  b0.i_dbus_cyc = cyc;
        end else begin
            b3.i_dbus_adr = adr; b3.i_dbus_dat = dat; b3.i_dbus_sel = sel;
            b3.i_dbus_we  = we;  b3.i_dbus_cyc = cyc;
        end
    endtask

    task automatic drive_i(input int d, input logic [31:0] adr, input logic cyc);
        if (d == 0) begin
            b0.i_ibus_adr = adr; b0.i_ibus_cyc = cyc;
        end else begin
            b3.i_ibus_adr = adr; b3.i_ibus_cyc = cyc;
        end
    endtask

    function automatic logic dack(input int d);
        return (d == 0) ? b0.o_dbus_ack : b3.o_dbus_ack;
    endfunction
    function automatic logic iack(input int d);
        return (d == 0) ? b0.o_ibus_ack : b3.o_ibus_ack;
    endfunction
    function automatic logic [31:0] drdt(input int d);
        return (d == 0) ? b0.o_dbus_rdt : b3.o_dbus_rdt;
    endfunction
    function automatic logic [31:0] irdt(input int d);
        return (d == 0) ? b0.o_ibus_rdt : b3.o_ibus_rdt;
    endfunction

    // One dbus transfer; returns on the falling edge where ack is seen
    // (lat = cycles since cyc was raised, -1 if no ack within the budget).
    task automatic dbus_xfer(input int d, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we,
                             output logic [31:0] rdt, output int lat, output logic other);
        @(negedge clk);
        drive_d(d, adr, dat, sel, we, 1'b1);
        lat = -1; rdt = 'x; other = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (iack(d)) other = 1'b1;
            if (dack(d)) begin
                lat = c; rdt = drdt(d);
                break;
            end
        end
        drive_d(d, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic ibus_xfer(input int d, input logic [31:0] adr,
                             output logic [31:0] rdt, output int lat, output logic other);
        @(negedge clk);
        drive_i(d, adr, 1'b1);
        lat = -1; rdt = 'x; other = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (dack(d)) other = 1'b1;
            if (iack(d)) begin
                lat = c; rdt = irdt(d);
                break;
            end
        end
        drive_i(d, '0, 1'b0);
    endtask

    initial begin
        logic [31:0] rdt;
        logic [31:0] dr;
        logic [31:0] ir;
        int          lat;
        int          dl;
        int          il;
        logic        other;
        logic        both;
        logic        seen;

        drive_d(0, '0, '0, '0, 1'b0, 1'b0); drive_i(0, '0, 1'b0);
        drive_d(1, '0, '0, '0, 1'b0, 1'b0); drive_i(1, '0, 1'b0);

        // Reset state
        #2;
        chk("rst_u0_dack", 32'(dack(0)), 32'd0);
        chk("rst_u0_iack", 32'(iack(0)), 32'd0);
        chk("rst_u0_drdt", drdt(0), 32'h0);
        chk("rst_u0_irdt", irdt(0), 32'h0);
        chk("rst_u3_dack", 32'(dack(1)), 32'd0);
        chk("rst_u3_drdt", drdt(1), 32'h0);
        @(negedge clk); @(negedge clk);
        rst0_n = 1'b1; rst3_n = 1'b1;

        // Preload word[2] = 0x13 through dbus, then fetch it on ibus
        dbus_xfer(0, 32'h8, 32'h0000_0013, 4'hF, 1'b1, rdt, lat, other);
        chk("wr8_lat", 32'(lat), 32'd2);
        ibus_xfer(0, 32'h8, rdt, lat, other);
        chk("fetch_lat", 32'(lat), 32'd2);
        chk("fetch_rdt", rdt, 32'h0000_0013);
        chk("fetch_no_dack", 32'(other), 32'd0);
        @(negedge clk);
        chk("fetch_pulse", 32'(iack(0)), 32'd0);

        // Byte-lane write: read-before-write data, then merged read-back
        dbus_xfer(0, 32'h10, 32'hAABB_CCDD, 4'hF, 1'b1, rdt, lat, other);
        chk("wr10_lat", 32'(lat), 32'd2);
        dbus_xfer(0, 32'h10, 32'h1122_3344, 4'b0101, 1'b1, rdt, lat, other);
        chk("bytewr_lat", 32'(lat), 32'd2);
        chk("bytewr_prewrite_rdt", rdt, 32'hAABB_CCDD);
        chk("bytewr_no_iack", 32'(other), 32'd0);
        dbus_xfer(0, 32'h10, '0, '0, 1'b0, rdt, lat, other);
        chk("bytewr_readback", rdt, 32'hAA22_CC44);

        // sel=0000 write completes but changes nothing
        dbus_xfer(0, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b1, rdt, lat, other);
        chk("sel0_lat", 32'(lat), 32'd2);
        dbus_xfer(0, 32'h10, '0, 4'hF, 1'b0, rdt, lat, other);
        chk("sel0_readback", rdt, 32'hAA22_CC44);
        chk("irdt_held", irdt(0), 32'h0000_0013);

        // Address wrap modulo DEPTH=8192
        dbus_xfer(0, 32'h4, 32'hCAFE_F00D, 4'hF, 1'b1, rdt, lat, other);
        dbus_xfer(0, 32'h0000_2004, '0, '0, 1'b0, rdt, lat, other);
        chk("wrap_dbus", rdt, 32'hCAFE_F00D);
        ibus_xfer(0, 32'hFFFF_E004, rdt, lat, other);
        chk("wrap_ibus", rdt, 32'hCAFE_F00D);

        // Tie: dbus first, ibus served 2 cycles after dbus ack drops
        @(negedge clk);
        drive_d(0, 32'h4, '0, '0, 1'b0, 1'b1);
        drive_i(0, 32'h8, 1'b1);
        dl = -1; il = -1; both = 1'b0; dr = 'x; ir = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (dack(0) && iack(0)) both = 1'b1;
            if (dack(0) && dl < 0) begin
                dl = c; dr = drdt(0);
                drive_d(0, '0, '0, '0, 1'b0, 1'b0);
            end
            if (iack(0)) begin
                il = c; ir = irdt(0);
                break;
            end
        end
        drive_i(0, '0, 1'b0);
        chk("tie_dbus_lat", 32'(dl), 32'd2);
        chk("tie_ibus_lat", 32'(il), 32'd5);
        chk("tie_never_both", 32'(both), 32'd0);
        chk("tie_drdt", dr, 32'hCAFE_F00D);
        chk("tie_irdt", ir, 32'h0000_0013);

        // Wait states (u3, WAIT_STATES=3)
        dbus_xfer(1, 32'h20, 32'h1234_5678, 4'hF, 1'b1, rdt, lat, other);
        chk("ws_wr_lat", 32'(lat), 32'd5);
        @(negedge clk);
        chk("ws_wr_pulse", 32'(dack(1)), 32'd0);
        dbus_xfer(1, 32'h20, '0, '0, 1'b0, rdt, lat, other);
        chk("ws_rd_lat", 32'(lat), 32'd5);
        chk("ws_rd_rdt", rdt, 32'h1234_5678);
        @(negedge clk);
        chk("ws_rd_pulse", 32'(dack(1)), 32'd0);

        // Abort: cyc dropped after one cycle
        @(negedge clk);
        drive_d(1, 32'h20, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
        @(negedge clk);
        drive_d(1, '0, '0, '0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dack(1)) seen = 1'b1;
        end
        chk("abort_no_ack", 32'(seen), 32'd0);
        dbus_xfer(1, 32'h20, '0, '0, 1'b0, rdt, lat, other);
        chk("abort_word_kept", rdt, 32'h1234_5678);

        // Reset mid-ACCESS during a write
        @(negedge clk);
        drive_d(1, 32'h20, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
        @(negedge clk); @(negedge clk);
        rst3_n = 1'b0;
        #1;
        chk("rstacc_dack", 32'(dack(1)), 32'd0);
        chk("rstacc_drdt", drdt(1), 32'h0);
        drive_d(1, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst3_n = 1'b1;
        dbus_xfer(1, 32'h20, '0, '0, 1'b0, rdt, lat, other);
        chk("rstacc_next_lat", 32'(lat), 32'd5);
        chk("rstacc_word_kept", rdt, 32'h1234_5678);

        // Reset during the ack cycle clears ack immediately
        dbus_xfer(1, 32'h20, '0, '0, 1'b0, rdt, lat, other);
        chk("rstack_lat", 32'(lat), 32'd5);
        rst3_n = 1'b0;
        #1;
        chk("rstack_dack_async", 32'(dack(1)), 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        dbus_xfer(1, 32'h20, '0, '0, 1'b0, rdt, lat, other);
        chk("rstack_next_rdt", rdt, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
        $finish;
    end

endmodule
